score_collector: RTL and testbench

SCORE_COLLECTOR -- requirements
Module: score_collector

---
 rtl/nn_pkg.sv | 18 +
 rtl/score_sat8.sv | 35 +++
 rtl/score_collector.sv | 106 ++++++++++
 tb/tb_score_collector.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared neural-net output-layer definitions used by the score collector and the argmax classifier.
// Holds the class count, score width and the packed lane-index formula.
package nn_pkg;

  localparam int N_CLASSES = 10;
  localparam int SCORE_W   = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } collect_state_t;

  // Lowest bit of class k inside a packed score array.
  function automatic int lane_lo(input int k);
    return k * SCORE_W;
  endfunction

endpackage

// File: rtl/score_sat8.sv
// Converts a signed accumulator to an 8-bit unsigned score after an arithmetic right shift.
// Define SCORE_SAT_EN to clamp to 0..255; otherwise the shifted value is truncated to 8 bits.
module score_sat8 #(
  parameter int ACC_W = 16,
  parameter int SHIFT = 4
) (
  input  logic [ACC_W-1:0] in_data,
  output logic [7:0]       score
);
  import nn_pkg::*;

  logic signed [ACC_W-1:0] shifted_s;

  assign shifted_s = $signed(in_data) >>> SHIFT;

`ifdef SCORE_SAT_EN
  // Clamp negative values to 0 and anything above 255 to 255.
  always_comb begin
    score = 8'd0;
    if (shifted_s[ACC_W-1]) begin
      score = 8'd0;
    end else if (|shifted_s[ACC_W-2:SCORE_W]) begin
      score = 8'd255;
    end else begin
      score = shifted_s[SCORE_W-1:0];
    end
  end
`else
  logic unused_hi_s;

  assign unused_hi_s = ^shifted_s[ACC_W-1:SCORE_W];
  assign score       = shifted_s[SCORE_W-1:0];
`endif

endmodule

// File: rtl/score_collector.sv
// Collects one frame of neuron scores into a packed 8-bit array and hands it to the argmax stage.
// Conversion mode is chosen by the SCORE_SAT_EN macro inside score_sat8.
module score_collector #(
  parameter int N_CLASSES = nn_pkg::N_CLASSES,
  parameter int ACC_W     = 16,
  parameter int SHIFT     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ACC_W-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_CLASSES*8-1:0] array,
  output logic                   frame_err
);
  import nn_pkg::*;

  localparam int CNT_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_CLASSES - 1);

  collect_state_t           state_r, state_next_s;
  logic [CNT_W-1:0]         count_r, count_next_s;
  logic [N_CLASSES*8-1:0]   array_r, array_next_s;
  logic                     err_r, err_next_s;
  logic                     in_ready_r, out_valid_r;
  logic [7:0]               score_s;
  logic                     at_last_lane_s;

  score_sat8 #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_score_sat8 (
    .in_data (in_data),
    .score   (score_s)
  );

  assign at_last_lane_s = (count_r == LAST_IDX);

  // Next-state logic: a frame closes on in_last or on the final lane, whichever comes first.
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    array_next_s = array_r;
    err_next_s   = err_r;
    case (state_r)
      COLLECT: begin
        if (in_valid) begin
          array_next_s[lane_lo(int'(count_r)) +: SCORE_W] = score_s;
          if (in_last || at_last_lane_s) begin
            state_next_s = FULL;
            count_next_s = {CNT_W{1'b0}};
            err_next_s   = in_last ^ at_last_lane_s;
          end else begin
            count_next_s = count_r + CNT_W'(1);
          end
        end else begin
          state_next_s = COLLECT;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_next_s = COLLECT;
          count_next_s = {CNT_W{1'b0}};
          array_next_s = {(N_CLASSES*8){1'b0}};
          err_next_s   = 1'b0;
        end else begin
          state_next_s = FULL;
        end
      end
      default: begin
        state_next_s = COLLECT;
        count_next_s = {CNT_W{1'b0}};
        array_next_s = {(N_CLASSES*8){1'b0}};
        err_next_s   = 1'b0;
      end
    endcase
  end

  // State and output registers; handshake flags are decoded from the next state so they are flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= COLLECT;
      count_r     <= {CNT_W{1'b0}};
      array_r     <= {(N_CLASSES*8){1'b0}};
      err_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      count_r     <= count_next_s;
      array_r     <= array_next_s;
      err_r       <= err_next_s;
      in_ready_r  <= (state_next_s == COLLECT);
      out_valid_r <= (state_next_s == FULL);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign array     = array_r;
  assign frame_err = err_r;

endmodule

// File: tb/tb_score_collector.sv
// Self-checking bench for score_collector: directed tables, corner sequences and a randomized stream
// checked against a frame-level reference model.
module tb_score_collector;

  localparam int NC = 10;
  localparam int AW = 16;
  localparam int SH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [NC*8-1:0] array;
  logic            frame_err;

  int checks = 0;
  int errors = 0;

  score_collector #(.N_CLASSES(NC), .ACC_W(AW), .SHIFT(SH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .array     (array),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [7:0]  exp;
  } vec_t;

  task automatic chk(input string name, input logic [NC*8-1:0] act, input logic [NC*8-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference conversion from the arithmetic definition.
  function automatic logic [7:0] conv(input logic [15:0] d);
    int v;
    v = int'($signed(d)) >>> SH;
`ifdef SCORE_SAT_EN
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
`else
    return v[7:0];
`endif
  endfunction

  function automatic logic [NC*8-1:0] build(input logic [15:0] q[$]);
    logic [NC*8-1:0] r;
    r = '0;
    foreach (q[i]) r[i*8 +: 8] = conv(q[i]);
    return r;
  endfunction

  task automatic send_beat(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", {79'b0, in_ready}, 80'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_full(input string name, input logic [NC*8-1:0] ea, input logic ee);
    chk({name, "_valid"}, {79'b0, out_valid}, 80'd1);
    chk({name, "_ready"}, {79'b0, in_ready}, 80'd0);
    chk({name, "_array"}, array, ea);
    chk({name, "_err"}, {79'b0, frame_err}, {79'b0, ee});
  endtask

  task automatic release_frame(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_rel_ready"}, {79'b0, in_ready}, 80'd1);
    chk({name, "_rel_valid"}, {79'b0, out_valid}, 80'd0);
    chk({name, "_rel_array"}, array, 80'd0);
    chk({name, "_rel_err"}, {79'b0, frame_err}, 80'd0);
  endtask

  initial begin
    vec_t            tbl[7];
    logic [15:0]     q[$];
    logic [NC*8-1:0] ea;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {79'b0, in_ready}, 80'd1);
    chk("rst_valid", {79'b0, out_valid}, 80'd0);
    chk("rst_array", array, 80'd0);
    chk("rst_err", {79'b0, frame_err}, 80'd0);

    // Conversion table: single-beat frames, result in lane 0.
`ifdef SCORE_SAT_EN
    tbl = '{'{16'h1000, 8'hFF}, '{16'hFFF0, 8'h00}, '{16'h0010, 8'h01}, '{16'h0FF0, 8'hFF},
            '{16'h8000, 8'h00}, '{16'h7FFF, 8'hFF}, '{16'h0125, 8'h12}};
`else
    tbl = '{'{16'h1000, 8'h00}, '{16'hFFF0, 8'hFF}, '{16'h0010, 8'h01}, '{16'h0FF0, 8'hFF},
            '{16'h8000, 8'h00}, '{16'h7FFF, 8'hFF}, '{16'h0125, 8'h12}};
`endif
    for (int i = 0; i < 7; i++) begin
      send_beat(tbl[i].d, 1'b1);
      ea = '0;
      ea[7:0] = tbl[i].exp;
      expect_full("conv", ea, 1'b1);
      release_frame("conv");
    end

    // Ten-beat frame 0x10..0xA0 terminated by in_last.
    for (int i = 0; i < NC; i++) begin
      send_beat(16'((i + 1) * 16), (i == NC - 1));
      if (i == NC - 2) chk("ten_early_valid", {79'b0, out_valid}, 80'd0);
    end
    ea = 80'h0A_09_08_07_06_05_04_03_02_01;
    expect_full("ten", ea, 1'b0);
    release_frame("ten");

    // Short frame closed by in_last.
    for (int i = 0; i < 3; i++) send_beat(16'h0120, (i == 2));
    ea = 80'h12_12_12;
    expect_full("short", ea, 1'b1);
    release_frame("short");

    // Ten beats without in_last close the frame with an error; the next beat starts a new frame.
    for (int i = 0; i < NC; i++) send_beat(16'h0200, 1'b0);
    ea = {NC{8'h20}};
    expect_full("nolast", ea, 1'b1);
    release_frame("nolast");
    send_beat(16'h0030, 1'b1);
    ea = 80'h03;
    expect_full("after_nolast", ea, 1'b1);
    release_frame("after_nolast");

    // Backpressure: frame stays stable while in_valid is pushed and out_ready is low.
    for (int i = 0; i < NC; i++) send_beat(16'h0050, (i == NC - 1));
    ea = {NC{8'h05}};
    in_valid = 1'b1;
    in_data  = 16'h7770;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", {79'b0, in_ready}, 80'd0);
      chk("bp_array", array, ea);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_rel_ready", {79'b0, in_ready}, 80'd1);
    chk("bp_rel_array", array, 80'd0);

    // Reset mid-frame discards it; the following frame lands from lane 0.
    for (int i = 0; i < 4; i++) send_beat(16'h0440, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", {79'b0, out_valid}, 80'd0);
    chk("midrst_ready", {79'b0, in_ready}, 80'd1);
    chk("midrst_array", array, 80'd0);
    for (int i = 0; i < NC; i++) begin
      send_beat(16'((i + 3) * 16), (i == NC - 1));
      if (i < NC - 1) chk("midrst_nov", {79'b0, out_valid}, 80'd0);
    end
    ea = 80'h0C_0B_0A_09_08_07_06_05_04_03;
    expect_full("midrst", ea, 1'b0);

    // Reset while FULL drops the pending frame.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("fullrst_valid", {79'b0, out_valid}, 80'd0);
    chk("fullrst_array", array, 80'd0);

    // Randomized stream against the frame model.
    q = {};
    for (int f = 0; f < 30; f++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        logic [15:0] d;
        logic        l;
        d = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 4095));
        l = (i == len - 1);
        send_beat(d, l);
        q.push_back(d);
        if (l || q.size() == NC) begin
          logic ee;
          int   hold;
          ee = !(l && q.size() == NC);
          ea = build(q);
          expect_full("rand", ea, ee);
          hold = $urandom_range(0, 3);
          for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 16'($urandom);
            @(negedge clk);
            chk("rand_hold_array", array, ea);
            chk("rand_hold_valid", {79'b0, out_valid}, 80'd1);
          end
          in_valid = 1'b0;
          release_frame("rand");
          q = {};
        end else begin
          chk("rand_nov", {79'b0, out_valid}, 80'd0);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
